// File: rtl/gate_truth_checker.sv
// Exhaustive 2-input gate sweep: drives {a,b} = 00..11, samples y_in after a settle time,
// builds a 4-bit truth table and compares it to EXPECTED. Optional macro: GATE_CHK_FAIL_CNT_EN.
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] table_out,
    output logic       match
`ifdef GATE_CHK_FAIL_CNT_EN
    ,
    output logic [7:0] fail_cnt
`endif
);

    localparam int unsigned   CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [3:0]    next_table;
    logic          last_cycle;

    // Table including the bit captured on the current edge, so match sees all four bits.
    always_comb begin
        next_table      = table_out;
        next_table[idx] = y_in;
        last_cycle      = (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
            match     <= 1'b0;
`ifdef GATE_CHK_FAIL_CNT_EN
            fail_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    if (start) begin
                        state     <= DRIVE;
                        idx       <= '0;
                        cnt       <= '0;
                        table_out <= '0;
                        match     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (last_cycle) begin
                        table_out <= next_table;
                        if (idx == 2'd3) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= (next_table == EXPECTED);
                            a_out <= 1'b0;
                            b_out <= 1'b0;
`ifdef GATE_CHK_FAIL_CNT_EN
                            if ((next_table != EXPECTED) && (fail_cnt != 8'hFF))
                                fail_cnt <= fail_cnt + 8'd1;
`endif
                        end else begin
                            idx            <= idx + 2'd1;
                            cnt            <= '0;
                            {a_out, b_out} <= idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: S=2 and S=1 instances driven by a selectable gate model.
module tb_gate_truth_checker;

    logic clk = 1'b0;
    logic rst;
    logic start1, start2;
    logic a1, b1, y1, busy1, done1, match1;
    logic a2, b2, y2, busy2, done2, match2;
    logic [3:0] tbl1, tbl2;
    logic yr1, yr2;
    int   mode;       // 0 NAND, 1 AND, 2 registered NAND, 3 stuck at 1
    int   nvec = 0;
    int   nerr = 0;
`ifdef GATE_CHK_FAIL_CNT_EN
    logic [7:0] fc1, fc2;
`endif

    always #5 clk = ~clk;

    gate_truth_checker #(.SETTLE_CYCLES(1), .EXPECTED(4'b0111)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .y_in(y1),
        .busy(busy1), .done(done1), .table_out(tbl1), .match(match1)
`ifdef GATE_CHK_FAIL_CNT_EN
        , .fail_cnt(fc1)
`endif
    );

    gate_truth_checker #(.SETTLE_CYCLES(2), .EXPECTED(4'b0111)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2), .y_in(y2),
        .busy(busy2), .done(done2), .table_out(tbl2), .match(match2)
`ifdef GATE_CHK_FAIL_CNT_EN
        , .fail_cnt(fc2)
`endif
    );

    always @(posedge clk) begin
        yr1 <= ~(a1 & b1);
        yr2 <= ~(a2 & b2);
    end

    always_comb begin
        case (mode)
            0:       begin y1 = ~(a1 & b1); y2 = ~(a2 & b2); end
            1:       begin y1 = a1 & b1;    y2 = a2 & b2;    end
            2:       begin y1 = yr1;        y2 = yr2;        end
            default: begin y1 = 1'b1;       y2 = 1'b1;       end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Launch one sweep on the chosen instance; lat = edges from accept to done, -1 on timeout.
    task automatic run_sweep(input int sel, output int lat);
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if ((sel == 1) ? done1 : done2) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start2 = 1'b1;
        tick();
        nvec++;
        if ({busy2, done2, a2, b2, tbl2, match2} !== 9'b0) begin
            nerr++;
            $display("FAIL reset_state: got %b, required 000000000", {busy2, done2, a2, b2, tbl2, match2});
        end
        rst = 1'b0; start2 = 1'b0;
        tick();
        nvec++;
        if (busy2 !== 1'b0) begin
            nerr++;
            $display("FAIL reset_vs_start: busy=%b, required 0", busy2);
        end
`ifdef GATE_CHK_FAIL_CNT_EN
        nvec++;
        if (fc2 !== 8'd0) begin
            nerr++;
            $display("FAIL reset_fail_cnt: got %0d, required 0", fc2);
        end
`endif
    endtask

    task automatic test_nand();
        int lat;
        do_reset();
        mode = 0;
        run_sweep(2, lat);
        nvec++;
        if (lat !== 8) begin nerr++; $display("FAIL nand_latency: got %0d, required 8", lat); end
        nvec++;
        if (tbl2 !== 4'b0111) begin nerr++; $display("FAIL nand_table: got %b, required 0111", tbl2); end
        nvec++;
        if (match2 !== 1'b1) begin nerr++; $display("FAIL nand_match: got %b, required 1", match2); end
        nvec++;
        if (busy2 !== 1'b0) begin nerr++; $display("FAIL nand_busy_at_done: got %b, required 0", busy2); end
        tick();
        nvec++;
        if (done2 !== 1'b0 || tbl2 !== 4'b0111 || match2 !== 1'b1) begin
            nerr++;
            $display("FAIL nand_hold: done=%b table=%b match=%b, required 0 0111 1", done2, tbl2, match2);
        end
`ifdef GATE_CHK_FAIL_CNT_EN
        nvec++;
        if (fc2 !== 8'd0) begin nerr++; $display("FAIL nand_fail_cnt: got %0d, required 0", fc2); end
`endif
    endtask

    task automatic test_and();
        int lat;
        do_reset();
        mode = 1;
        run_sweep(2, lat);
        nvec++;
        if (lat !== 8) begin nerr++; $display("FAIL and_latency: got %0d, required 8", lat); end
        nvec++;
        if (tbl2 !== 4'b1000) begin nerr++; $display("FAIL and_table: got %b, required 1000", tbl2); end
        nvec++;
        if (match2 !== 1'b0) begin nerr++; $display("FAIL and_match: got %b, required 0", match2); end
`ifdef GATE_CHK_FAIL_CNT_EN
        nvec++;
        if (fc2 !== 8'd1) begin nerr++; $display("FAIL and_fail_cnt1: got %0d, required 1", fc2); end
`endif
        tick();
        run_sweep(2, lat);
        nvec++;
        if (tbl2 !== 4'b1000) begin nerr++; $display("FAIL and_table2: got %b, required 1000", tbl2); end
`ifdef GATE_CHK_FAIL_CNT_EN
        nvec++;
        if (fc2 !== 8'd2) begin nerr++; $display("FAIL and_fail_cnt2: got %0d, required 2", fc2); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [1:0] ab_exp [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        int done_at [$];
        do_reset();
        mode = 0;
        start2 = 1'b1;
        for (int t = 0; t < 55; t++) begin
            if (t == 40) start2 = 1'b0;
            tick();   // edge E(t)
            if (t < 8) begin
                nvec++;
                if ({a2, b2} !== ab_exp[t]) begin
                    nerr++;
                    $display("FAIL held_ab_seq[%0d]: got %b, required %b", t, {a2, b2}, ab_exp[t]);
                end
            end
            if (done2) done_at.push_back(t);
        end
        nvec++;
        if (done_at.size() !== 4) begin
            nerr++;
            $display("FAIL held_done_count: got %0d, required 4", done_at.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                nvec++;
                if (done_at[i] !== 8 + 10 * i) begin
                    nerr++;
                    $display("FAIL held_done_edge[%0d]: got E%0d, required E%0d", i, done_at[i], 8 + 10 * i);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        int seen;
        do_reset();
        mode = 0;
        start2 = 1'b1;
        tick();           // E0
        start2 = 1'b0;
        tick();           // E1
        tick();           // E2, bit0 captured
        rst = 1'b1;
        tick();           // E3
        rst = 1'b0;
        nvec++;
        if ({busy2, a2, b2, tbl2, done2} !== 8'b0) begin
            nerr++;
            $display("FAIL midrst_state: busy=%b ab=%b%b table=%b done=%b, required all 0",
                     busy2, a2, b2, tbl2, done2);
        end
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (done2 || busy2) seen++;
        end
        nvec++;
        if (seen !== 0) begin nerr++; $display("FAIL midrst_no_done: active cycles %0d, required 0", seen); end
        run_sweep(2, lat);
        nvec++;
        if (tbl2 !== 4'b0111 || match2 !== 1'b1) begin
            nerr++;
            $display("FAIL midrst_fresh: table=%b match=%b, required 0111 1", tbl2, match2);
        end
    endtask

    task automatic test_registered();
        int lat;
        do_reset();
        mode = 2;
        tick();
        run_sweep(1, lat);
        nvec++;
        if (lat !== 4) begin nerr++; $display("FAIL reg_s1_latency: got %0d, required 4", lat); end
        nvec++;
        if (tbl1 !== 4'b1111 || match1 !== 1'b0) begin
            nerr++;
            $display("FAIL reg_s1: table=%b match=%b, required 1111 0", tbl1, match1);
        end
        run_sweep(2, lat);
        nvec++;
        if (tbl2 !== 4'b0111 || match2 !== 1'b1) begin
            nerr++;
            $display("FAIL reg_s2: table=%b match=%b, required 0111 1", tbl2, match2);
        end
    endtask

    task automatic test_saturate();
        int lat;
        do_reset();
        mode = 3;
        for (int s = 0; s < 256; s++) begin
            run_sweep(1, lat);
            nvec++;
            if (tbl1 !== 4'b1111 || match1 !== 1'b0 || lat !== 4) begin
                nerr++;
                $display("FAIL stuck_sweep[%0d]: table=%b match=%b lat=%0d, required 1111 0 4",
                         s, tbl1, match1, lat);
            end
`ifdef GATE_CHK_FAIL_CNT_EN
            nvec++;
            if (fc1 !== ((s < 255) ? 8'(s + 1) : 8'd255)) begin
                nerr++;
                $display("FAIL stuck_fail_cnt[%0d]: got %0d, required %0d", s, fc1, (s < 255) ? s + 1 : 255);
            end
`endif
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; start1 = 1'b0; start2 = 1'b0; mode = 0;
        test_reset();
        test_nand();
        test_and();
        test_back_to_back();
        test_mid_reset();
        test_registered();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
